ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_if.sv | 49 ++++
 rtl/ex_mem_stage.sv | 110 +++++++++++
 tb/tb_ex_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// Execute-to-memory pipeline bus: instruction payload from EX and the
// registered stage outputs handed on to MEM.
interface ex_mem_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic signed [DW-1:0] alu_result;
  logic [2:0]           alu_flags;
  logic                 alu_done;
  logic [2:0]           alu_op;
  logic                 is_alu;
  logic [3:0]           rd_addr;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic [DW-1:0]        store_data;
  logic                 is_branch;
  logic [2:0]           branch_cond;
  logic [DW-1:0]        branch_target;

  logic                 out_valid;
  logic signed [DW-1:0] out_result;
  logic [3:0]           out_rd;
  logic                 out_reg_write;
  logic                 out_mem_read;
  logic                 out_mem_write;
  logic [DW-1:0]        out_store_data;
  logic [2:0]           flags_q;
  logic                 branch_taken;
  logic [DW-1:0]        branch_target_q;

  modport master (
    output in_valid, alu_result, alu_flags, alu_done, alu_op, is_alu,
           rd_addr, reg_write, mem_read, mem_write, store_data,
           is_branch, branch_cond, branch_target,
    input  out_valid, out_result, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_store_data, flags_q, branch_taken,
           branch_target_q
  );

  modport slave (
    input  in_valid, alu_result, alu_flags, alu_done, alu_op, is_alu,
           rd_addr, reg_write, mem_read, mem_write, store_data,
           is_branch, branch_cond, branch_target,
    output out_valid, out_result, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_store_data, flags_q, branch_taken,
           branch_target_q
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural flag register and
// conditional-branch resolution against the flags held before this edge.
module ex_mem_stage #(
  parameter int DW = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     stall,
  input  logic     flush,
  ex_mem_if.slave  bus
);

  // Flags are {Z,V,N}
  function automatic logic branch_ok(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n, r;
    z = f[2];
    v = f[1];
    n = f[0];
    r = 1'b0;
    case (cond)
      3'b000:  r = !z;
      3'b001:  r = z;
      3'b010:  r = !z && !n;
      3'b011:  r = n;
      3'b100:  r = z || (!z && !n);
      3'b101:  r = n || z;
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Shifts leave the flags alone; arithmetic/logic ops up to INC set them.
  function automatic logic sets_flags(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  logic                 vld_p1;
  logic signed [DW-1:0] result_p1;
  logic [3:0]           rd_p1;
  logic                 reg_write_p1;
  logic                 mem_read_p1;
  logic                 mem_write_p1;
  logic [DW-1:0]        store_data_p1;
  logic [2:0]           flags_p1;
  logic                 taken_p1;
  logic [DW-1:0]        target_p1;

  logic accept;
  logic flag_load;

  assign accept    = bus.in_valid && !stall && !flush && (!bus.is_alu || bus.alu_done);
  // A branch that also claims the ALU is treated purely as a branch.
  assign flag_load = bus.is_alu && !bus.is_branch && sets_flags(bus.alu_op);

  // ---- EX -> MEM register boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      result_p1     <= '0;
      rd_p1         <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      store_data_p1 <= '0;
      flags_p1      <= '0;
      taken_p1      <= 1'b0;
      target_p1     <= '0;
    end else if (flush) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      taken_p1     <= 1'b0;
    end else if (stall) begin
      taken_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1        <= 1'b1;
      result_p1     <= bus.alu_result;
      rd_p1         <= bus.rd_addr;
      reg_write_p1  <= bus.reg_write;
      mem_read_p1   <= bus.mem_read;
      mem_write_p1  <= bus.mem_write;
      store_data_p1 <= bus.store_data;
      taken_p1      <= bus.is_branch && branch_ok(bus.branch_cond, flags_p1);
      if (bus.is_branch)
        target_p1 <= bus.branch_target;
      if (flag_load)
        flags_p1 <= bus.alu_flags;
    end else begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      taken_p1     <= 1'b0;
    end
  end

  assign bus.out_valid       = vld_p1;
  assign bus.out_result      = result_p1;
  assign bus.out_rd          = rd_p1;
  assign bus.out_reg_write   = reg_write_p1;
  assign bus.out_mem_read    = mem_read_p1;
  assign bus.out_mem_write   = mem_write_p1;
  assign bus.out_store_data  = store_data_p1;
  assign bus.flags_q         = flags_p1;
  assign bus.branch_taken    = taken_p1;
  assign bus.branch_target_q = target_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// run compared against a rule-level reference model.
module tb_ex_mem_stage;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;

  int total = 0;
  int bad   = 0;

  ex_mem_if #(.DW(DW)) bus ();

  ex_mem_stage #(.DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_valid, m_rw, m_mr, m_mw, m_taken;
  bit [DW-1:0] m_result, m_sd, m_tgt;
  bit [3:0]    m_rd;
  bit [2:0]    m_flags;

  task automatic model_update();
    bit z, v, n;
    bit cond_tbl [8];
    bit can_go;
    z = m_flags[2]; v = m_flags[1]; n = m_flags[0];
    cond_tbl = '{!z, z, !z && !n, n, z || (!z && !n), n || z, v, 1'b1};
    can_go = bus.in_valid && (!bus.is_alu || bus.alu_done);
    if (!rst_n) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken} = '0;
      m_result = '0; m_sd = '0; m_tgt = '0; m_rd = '0; m_flags = '0;
    end else if (flush || (!stall && !can_go)) begin
      {m_valid, m_rw, m_mr, m_mw, m_taken} = '0;
    end else if (stall) begin
      m_taken = 1'b0;
    end else begin
      m_valid  = 1'b1;
      m_result = bus.alu_result;
      m_rd     = bus.rd_addr;
      m_rw     = bus.reg_write;
      m_mr     = bus.mem_read;
      m_mw     = bus.mem_write;
      m_sd     = bus.store_data;
      m_taken  = bus.is_branch && cond_tbl[bus.branch_cond];
      if (bus.is_branch) m_tgt = bus.branch_target;
      if (bus.is_alu && !bus.is_branch && (bus.alu_op inside {[3'd0:3'd4]}))
        m_flags = bus.alu_flags;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0;
    bus.in_valid = 0; bus.alu_result = '0; bus.alu_flags = '0; bus.alu_done = 0;
    bus.alu_op = '0; bus.is_alu = 0; bus.rd_addr = '0; bus.reg_write = 0;
    bus.mem_read = 0; bus.mem_write = 0; bus.store_data = '0; bus.is_branch = 0;
    bus.branch_cond = '0; bus.branch_target = '0;
  endtask

  task automatic drive_alu(input logic [2:0] op, input logic [DW-1:0] res, input logic [2:0] fl);
    bus.in_valid = 1; bus.is_alu = 1; bus.alu_done = 1; bus.is_branch = 0;
    bus.alu_op = op; bus.alu_result = res; bus.alu_flags = fl;
    bus.reg_write = 1; bus.rd_addr = 4'd3; bus.store_data = 16'hBEEF;
  endtask

  task automatic drive_branch(input logic [2:0] cond, input logic [DW-1:0] tgt);
    bus.in_valid = 1; bus.is_alu = 0; bus.alu_done = 0; bus.is_branch = 1;
    bus.branch_cond = cond; bus.branch_target = tgt; bus.reg_write = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    drive_alu(3'b000, 16'h5A5A, 3'b111);
    step(); step();
    total++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.out_store_data} !== '0) begin
      bad++; $display("FAIL reset_outs got=%h want=0",
        {bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.out_store_data});
    end
    total++;
    if ({bus.flags_q, bus.branch_taken, bus.branch_target_q} !== '0) begin
      bad++; $display("FAIL reset_flags_branch got=%h want=0", {bus.flags_q, bus.branch_taken, bus.branch_target_q});
    end
    rst_n = 1;
    set_idle();
    step();
  endtask

  task automatic test_add();
    drive_alu(3'b000, 16'h0000, 3'b100);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0000) begin
      bad++; $display("FAIL add_out got=%b/%h want=1/0000", bus.out_valid, bus.out_result);
    end
    total++;
    if (bus.flags_q !== 3'b100) begin
      bad++; $display("FAIL add_flags got=%b want=100", bus.flags_q);
    end
    set_idle();
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0) begin
      bad++; $display("FAIL idle_bubble got=%b%b want=00", bus.out_valid, bus.out_reg_write);
    end
  endtask

  task automatic test_flag_hold();
    drive_alu(3'b001, 16'h0010, 3'b001);
    step();
    drive_alu(3'b111, 16'h0020, 3'b000);
    step();
    total++;
    if (bus.flags_q !== 3'b001) begin
      bad++; $display("FAIL sll_flag_hold got=%b want=001", bus.flags_q);
    end
    total++;
    if (bus.out_result !== 16'h0020) begin
      bad++; $display("FAIL sll_result got=%h want=0020", bus.out_result);
    end
    set_idle();
    step();
  endtask

  task automatic test_branch();
    drive_alu(3'b000, 16'h0000, 3'b100);
    step();
    drive_branch(3'b001, 16'h0040);
    step();
    total++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target_q !== 16'h0040) begin
      bad++; $display("FAIL branch_taken got=%b/%h want=1/0040", bus.branch_taken, bus.branch_target_q);
    end
    set_idle();
    step();
    total++;
    if (bus.branch_taken !== 1'b0) begin
      bad++; $display("FAIL branch_pulse got=%b want=0", bus.branch_taken);
    end
    drive_branch(3'b000, 16'h0040);
    step();
    total++;
    if (bus.branch_taken !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL branch_not_taken got=%b/%b want=0/1", bus.branch_taken, bus.out_valid);
    end
    // Branch that also asserts is_alu: taken, flags untouched
    drive_branch(3'b111, 16'h0080);
    bus.is_alu = 1; bus.alu_done = 1; bus.alu_op = 3'b000; bus.alu_flags = 3'b010;
    step();
    total++;
    if (bus.branch_taken !== 1'b1 || bus.flags_q !== 3'b100) begin
      bad++; $display("FAIL branch_alu got=%b/%b want=1/100", bus.branch_taken, bus.flags_q);
    end
    set_idle();
    step();
  endtask

  task automatic test_stall();
    drive_alu(3'b011, 16'h1234, 3'b000);
    step();
    total++;
    if (bus.out_result !== 16'h1234 || bus.flags_q !== 3'b000) begin
      bad++; $display("FAIL xor_accept got=%h/%b want=1234/000", bus.out_result, bus.flags_q);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(3'($urandom_range(0, 4)), 16'($urandom), 3'b111);
      step();
      total++;
      if (bus.out_result !== 16'h1234 || bus.out_valid !== 1'b1 || bus.flags_q !== 3'b000) begin
        bad++; $display("FAIL stall_hold got=%h/%b/%b want=1234/1/000",
          bus.out_result, bus.out_valid, bus.flags_q);
      end
    end
    set_idle();
    step();
  endtask

  task automatic test_flush_stall();
    drive_alu(3'b000, 16'h0777, 3'b000);
    step();
    drive_alu(3'b000, 16'h0999, 3'b111);
    stall = 1; flush = 1;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0) begin
      bad++; $display("FAIL flush_stall got=%b%b want=00", bus.out_valid, bus.out_reg_write);
    end
    total++;
    if (bus.out_result !== 16'h0777 || bus.flags_q !== 3'b000) begin
      bad++; $display("FAIL flush_data_hold got=%h/%b want=0777/000", bus.out_result, bus.flags_q);
    end
    set_idle();
    step();
  endtask

  task automatic test_alu_not_done_and_reset();
    drive_alu(3'b000, 16'h0ABC, 3'b010);
    bus.alu_done = 0;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.flags_q !== 3'b000) begin
      bad++; $display("FAIL alu_not_done got=%b/%b want=0/000", bus.out_valid, bus.flags_q);
    end
    bus.alu_done = 1;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.flags_q !== 3'b010) begin
      bad++; $display("FAIL alu_done got=%b/%b want=1/010", bus.out_valid, bus.flags_q);
    end
    rst_n = 0;
    step();
    total++;
    if ({bus.out_valid, bus.out_result, bus.out_reg_write, bus.flags_q, bus.branch_taken} !== '0) begin
      bad++; $display("FAIL reset_mid got=%h want=0",
        {bus.out_valid, bus.out_result, bus.out_reg_write, bus.flags_q, bus.branch_taken});
    end
    rst_n = 1;
    drive_alu(3'b100, 16'h0042, 3'b001);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0042) begin
      bad++; $display("FAIL post_reset_accept got=%b/%h want=1/0042", bus.out_valid, bus.out_result);
    end
    set_idle();
    step();
  endtask

  task automatic test_random();
    logic [59:0] act, exp;
    for (int i = 0; i < 400; i++) begin
      rst_n            = ($urandom_range(0, 39) != 0);
      stall            = ($urandom_range(0, 4) == 0);
      flush            = ($urandom_range(0, 7) == 0);
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.is_alu       = $urandom_range(0, 1);
      bus.alu_done     = ($urandom_range(0, 3) != 0);
      bus.is_branch    = ($urandom_range(0, 3) == 0);
      bus.alu_op       = 3'($urandom);
      bus.alu_flags    = 3'($urandom);
      bus.alu_result   = 16'($urandom);
      bus.rd_addr      = 4'($urandom);
      bus.reg_write    = $urandom_range(0, 1);
      bus.mem_read     = $urandom_range(0, 1);
      bus.mem_write    = $urandom_range(0, 1);
      bus.store_data   = 16'($urandom);
      bus.branch_cond  = 3'($urandom);
      bus.branch_target = 16'($urandom);
      step();
      act = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.out_mem_read,
             bus.out_mem_write, bus.out_store_data, bus.flags_q, bus.branch_taken,
             (bus.branch_taken === 1'b1) ? bus.branch_target_q : 16'h0};
      exp = {m_valid, m_result, m_rd, m_rw, m_mr, m_mw, m_sd, m_flags, m_taken,
             m_taken ? m_tgt : 16'h0};
      total++;
      if (act !== exp) begin
        bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, act, exp);
      end
    end
    rst_n = 1;
    set_idle();
    step();
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    test_reset();
    test_add();
    test_flag_hold();
    test_branch();
    test_stall();
    test_flush_stall();
    test_alu_not_done_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
